// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package unified_mem_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Owner encoding stored in the owner latch.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Width of the latency counter and the starvation counter.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between IF and DM plus the IF starvation counter.
// Latency: win_dm is combinational; the starvation count updates on the clock edge.
// Backpressure: none; evaluated every arbitration cycle.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   if_req, dm_req    effective (already masked) requests
//   arb_cycle         high while the arbiter is idle and may grant
//   win_dm            1 = DM wins, 0 = IF wins (meaningful when a request exists)
module mem_arb_prio
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic if_req,
  input  logic dm_req,
  input  logic arb_cycle,
  output logic win_dm
);

  logic [CNT_W-1:0] starveCnt;
  logic             starved;

  assign starved = (starveCnt == CNT_W'(STARVE_MAX));

  // DM has priority unless IF has lost STARVE_MAX arbitrations in a row.
  assign win_dm = dm_req && !(if_req && starved);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starveCnt <= '0;
    end else if (arb_cycle) begin
      // No IF demand, or IF just won: the losing streak ends.
      if (!if_req || !win_dm) begin
        starveCnt <= '0;
      end else if (!starved) begin
        starveCnt <= starveCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-ported memory between IF and DM requesters.
// Latency: gnt/mem_en one cycle after the request, rvalid MEM_LAT+2 cycles after it.
// Backpressure: one access in flight; other requests wait (held high) until granted.
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-low reset
//   if_req/if_addr               IF read request, held until if_rvalid
//   if_gnt/if_rvalid/if_rdata    IF accept pulse, completion pulse, read data
//   dm_req/dm_we/dm_addr/dm_wdata  DM read/write request, held until dm_rvalid
//   dm_gnt/dm_rvalid/dm_rdata    DM accept pulse, completion pulse, read data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory side
//   busy                         high while an access is in flight
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner;

  logic ifEff;
  logic dmEff;
  logic winDm;
  logic arbCycle;

  // A requester still holding req during its own rvalid cycle is not re-granted.
  assign ifEff    = if_req && !if_rvalid;
  assign dmEff    = dm_req && !dm_rvalid;
  assign arbCycle = (state == IDLE);

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) uPrio (
    .clock    (clock),
    .reset    (reset),
    .if_req   (ifEff),
    .dm_req   (dmEff),
    .arb_cycle(arbCycle),
    .win_dm   (winDm)
  );

  // mem_addr/mem_we/mem_wdata double as the request latches for the access.
  // cnt is loaded with MEM_LAT on the strobe and reaches 0 in the cycle the
  // memory data is valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= OWN_IF;
      busy      <= 1'b0;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      mem_en    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (ifEff || dmEff) begin
            owner    <= winDm ? OWN_DM : OWN_IF;
            mem_addr <= winDm ? dm_addr : if_addr;
            mem_we   <= winDm && dm_we;
            if (winDm) begin
              mem_wdata <= dm_wdata;
            end
            if_gnt <= !winDm;
            dm_gnt <= winDm;
            mem_en <= 1'b1;
            busy   <= 1'b1;
            cnt    <= CNT_W'(MEM_LAT);
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            // Writes complete without touching the read-data registers.
            if (!mem_we) begin
              if (owner == OWN_DM) begin
                dm_rdata <= mem_rdata;
              end else begin
                if_rdata <= mem_rdata;
              end
            end
            if_rvalid <= (owner == OWN_IF);
            dm_rvalid <= (owner == OWN_DM);
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level schedule model.
// Clock period 10; inputs driven and outputs sampled 1 after the rising edge.
module tb_unified_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt, dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  always #5 clock = ~clock;

  unified_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;  // cycles after the previous completion (0 = in its rvalid cycle)
  } req_t;

  req_t ifQ[$];
  req_t dmQ[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // requester state
  bit ifAct = 0, dmAct = 0;
  int ifStartAt = 0, dmStartAt = 0;

  // schedule model: one access at a time, grant next cycle, done LAT+2 after arbitration
  int          mGnt = -100, mRv = -100, mNextArb = 0, mStarve = 0;
  bit          mOwnerDm = 0, mWe = 0;
  logic [31:0] mAddr = '0, mWdata = '0, mData = '0;
  logic [31:0] mIfRdata = '0, mDmRdata = '0;
  logic [31:0] modelMem[16];

  // memory responder
  logic [31:0] physMem[16];
  int          rdAt = -100;
  logic [31:0] rdVal = '0;
  logic [31:0] lastWrData = '0;

  // observed DUT events
  int ifGntAt = -1, ifRvAt = -1, dmGntAt = -1, dmRvAt = -1;
  int ifGntCount = 0, dmGntCount = 0, dmRvCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    a = ($urandom() & 32'hFFFF_FFC0) | ($urandom_range(0, 15) << 2);
    return a;
  endfunction

  task automatic checkAllZero(input string pfx);
    checkVal({pfx, "if_gnt"}, if_gnt, 0);
    checkVal({pfx, "if_rvalid"}, if_rvalid, 0);
    checkVal({pfx, "if_rdata"}, if_rdata, 0);
    checkVal({pfx, "dm_gnt"}, dm_gnt, 0);
    checkVal({pfx, "dm_rvalid"}, dm_rvalid, 0);
    checkVal({pfx, "dm_rdata"}, dm_rdata, 0);
    checkVal({pfx, "mem_en"}, mem_en, 0);
    checkVal({pfx, "mem_we"}, mem_we, 0);
    checkVal({pfx, "mem_addr"}, mem_addr, 0);
    checkVal({pfx, "mem_wdata"}, mem_wdata, 0);
    checkVal({pfx, "busy"}, busy, 0);
  endtask

  task automatic checkCycle();
    bit eIfRv, eDmRv;
    eIfRv = (cyc == mRv) && !mOwnerDm;
    eDmRv = (cyc == mRv) && mOwnerDm;
    if (cyc == mRv && !mWe) begin
      if (mOwnerDm) mDmRdata = mData;
      else          mIfRdata = mData;
    end
    checkVal("mem_en", mem_en, (cyc == mGnt));
    checkVal("busy", busy, (cyc >= mGnt && cyc < mRv));
    checkVal("if_gnt", if_gnt, (cyc == mGnt && !mOwnerDm));
    checkVal("dm_gnt", dm_gnt, (cyc == mGnt && mOwnerDm));
    checkVal("if_rvalid", if_rvalid, eIfRv);
    checkVal("dm_rvalid", dm_rvalid, eDmRv);
    checkVal("if_rdata", if_rdata, mIfRdata);
    checkVal("dm_rdata", dm_rdata, mDmRdata);
    if (cyc == mGnt) begin
      checkVal("mem_we", mem_we, mWe);
      if (mWe) checkVal("mem_wdata", mem_wdata, mWdata);
    end
    if (cyc >= mGnt && cyc < mRv) checkVal("mem_addr", mem_addr, mAddr);
    if (if_gnt)    begin ifGntAt = cyc; ifGntCount++; end
    if (dm_gnt)    begin dmGntAt = cyc; dmGntCount++; end
    if (if_rvalid) ifRvAt = cyc;
    if (dm_rvalid) begin dmRvAt = cyc; dmRvCount++; end
  endtask

  // Memory: writes land on the strobe, reads return exactly LAT cycles later;
  // any other cycle carries junk so a mistimed sample is visible.
  task automatic respond();
    if (mem_en) begin
      if (mem_we) begin
        physMem[mem_addr[5:2]] = mem_wdata;
        lastWrData = mem_wdata;
      end else begin
        rdAt  = cyc + LAT;
        rdVal = physMem[mem_addr[5:2]];
      end
    end
    if (cyc == rdAt) mem_rdata = rdVal;
    else             mem_rdata = $urandom();
  endtask

  task automatic drive();
    if (ifAct && cyc == mRv && !mOwnerDm) begin
      ifQ.delete(0);
      ifAct = 0;
      if (ifQ.size() > 0) ifStartAt = cyc + ifQ[0].delay;
    end
    if (!ifAct && ifQ.size() > 0 && cyc >= ifStartAt) ifAct = 1;
    if_req = ifAct;
    if (ifAct) if_addr = ifQ[0].addr;
    else       if_addr = $urandom();

    if (dmAct && cyc == mRv && mOwnerDm) begin
      dmQ.delete(0);
      dmAct = 0;
      if (dmQ.size() > 0) dmStartAt = cyc + dmQ[0].delay;
    end
    if (!dmAct && dmQ.size() > 0 && cyc >= dmStartAt) dmAct = 1;
    dm_req = dmAct;
    if (dmAct) begin
      dm_we    = dmQ[0].we;
      dm_addr  = dmQ[0].addr;
      dm_wdata = dmQ[0].wdata;
    end else begin
      dm_we    = $urandom_range(0, 1);
      dm_addr  = $urandom();
      dm_wdata = $urandom();
    end
  endtask

  // Arbitration decision for this cycle, from the rules: completing owner is
  // ignored, DM beats IF unless IF has lost SMAX times running.
  task automatic modelArb();
    bit ifE, dmE, winDm;
    if (cyc < mNextArb) return;
    ifE = ifAct && !(cyc == mRv && !mOwnerDm);
    dmE = dmAct && !(cyc == mRv && mOwnerDm);
    if (!ifE) mStarve = 0;
    if (!ifE && !dmE) return;
    winDm = dmE && !(ifE && mStarve == SMAX);
    if (ifE) mStarve = winDm ? ((mStarve < SMAX) ? mStarve + 1 : SMAX) : 0;
    mOwnerDm = winDm;
    mGnt     = cyc + 1;
    mRv      = cyc + 2 + LAT;
    mNextArb = mRv;
    if (winDm) begin
      mAddr  = dmQ[0].addr;
      mWe    = dmQ[0].we;
      mWdata = dmQ[0].wdata;
    end else begin
      mAddr = ifQ[0].addr;
      mWe   = 0;
    end
    if (mWe) modelMem[mAddr[5:2]] = mWdata;
    else     mData = modelMem[mAddr[5:2]];
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    checkCycle();
    respond();
    drive();
    modelArb();
  endtask

  task automatic runUntilIdle(input int bound, input string tag);
    int n;
    n = 0;
    while ((ifQ.size() > 0 || dmQ.size() > 0 || cyc < mRv) && n < bound) begin
      step();
      n++;
    end
    checkVal({tag, "_timeout"}, (n < bound), 1'b1);
  endtask

  function automatic req_t mk(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int delay);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.delay = delay;
    return r;
  endfunction

  initial begin
    int t0, savedRv, gi, gd;

    for (int i = 0; i < 16; i++) physMem[i] = $urandom();
    physMem[4] = 32'hDEADBEEF;  // 0x10
    physMem[8] = 32'h12345678;  // 0x20
    for (int i = 0; i < 16; i++) modelMem[i] = physMem[i];

    // reset state
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkAllZero("reset_");
    #2 reset = 1'b1;

    // single IF read
    ifQ.push_back(mk(0, 32'h10, 0, 0));
    t0 = cyc + 1; ifStartAt = t0;
    runUntilIdle(50, "t1");
    checkVal("t1_gnt_lat", ifGntAt - t0, 1);
    checkVal("t1_rv_lat", ifRvAt - t0, LAT + 2);
    checkVal("t1_rdata", if_rdata, 32'hDEADBEEF);

    // simultaneous IF + DM: DM first
    repeat (2) step();
    dmQ.push_back(mk(0, 32'h20, 0, 0));
    ifQ.push_back(mk(0, 32'h30, 0, 0));
    t0 = cyc + 1; ifStartAt = t0; dmStartAt = t0;
    runUntilIdle(50, "t2");
    checkVal("t2_dm_gnt", dmGntAt - t0, 1);
    checkVal("t2_dm_rv", dmRvAt - t0, LAT + 2);
    checkVal("t2_dm_rdata", dm_rdata, 32'h12345678);
    checkVal("t2_if_gnt", ifGntAt - t0, LAT + 3);
    checkVal("t2_if_rv", ifRvAt - t0, 2 * LAT + 4);

    // DM write leaves dm_rdata alone
    repeat (2) step();
    dmQ.push_back(mk(1, 32'h40, 32'hA5A5A5A5, 0));
    t0 = cyc + 1; dmStartAt = t0;
    runUntilIdle(50, "t3");
    checkVal("t3_dm_rv", dmRvAt - t0, LAT + 2);
    checkVal("t3_dm_rdata_kept", dm_rdata, 32'h12345678);
    checkVal("t3_wdata", lastWrData, 32'hA5A5A5A5);
    checkVal("t3_mem", physMem[0], 32'hA5A5A5A5);

    // owner masking: DM keeps req high through its rvalid cycle
    repeat (2) step();
    gd = dmGntCount;
    dmQ.push_back(mk(0, 32'h50, 0, 0));
    dmQ.push_back(mk(0, 32'h54, 0, 0));
    t0 = cyc + 1; dmStartAt = t0;
    runUntilIdle(60, "t4");
    checkVal("t4_regrant", dmGntAt - t0, LAT + 4);
    checkVal("t4_rv2", dmRvAt - t0, 2 * LAT + 5);
    checkVal("t4_gnt_count", dmGntCount - gd, 2);

    // reset in cycle 2 of a DM read
    repeat (2) step();
    dmQ.push_back(mk(0, 32'h60, 0, 0));
    t0 = cyc + 1; dmStartAt = t0;
    savedRv = dmRvCount;
    while (cyc < t0 + 2) step();
    #2 reset = 1'b0;
    #1;
    checkAllZero("midrst_");
    mGnt = -100; mRv = -100; mNextArb = 0; mStarve = 0;
    mIfRdata = '0; mDmRdata = '0; rdAt = -100;
    ifQ.delete(); dmQ.delete(); ifAct = 0; dmAct = 0;
    if_req = 1'b0; dm_req = 1'b0;
    repeat (2) step();
    #3 reset = 1'b1;
    repeat (6) step();
    checkVal("t5_no_rvalid", dmRvCount, savedRv);
    ifQ.push_back(mk(0, 32'h14, 0, 0));
    t0 = cyc + 1; ifStartAt = t0;
    runUntilIdle(50, "t5");
    checkVal("t5_if_rv", ifRvAt - t0, LAT + 2);

    // both requesting continuously
    repeat (2) step();
    gi = ifGntCount; gd = dmGntCount;
    for (int i = 0; i < 8; i++) begin
      ifQ.push_back(mk(0, randAddr(), 0, 0));
      dmQ.push_back(mk(0, randAddr(), 0, 0));
    end
    t0 = cyc + 1; ifStartAt = t0; dmStartAt = t0;
    runUntilIdle(400, "t6");
    checkVal("t6_if_served", ifGntCount - gi, 8);
    checkVal("t6_dm_served", dmGntCount - gd, 8);

    // random traffic
    repeat (2) step();
    gi = ifGntCount; gd = dmGntCount;
    for (int i = 0; i < 120; i++) begin
      ifQ.push_back(mk(0, randAddr(), 0, $urandom_range(0, 4)));
      dmQ.push_back(mk($urandom_range(0, 1), randAddr(), $urandom(), $urandom_range(0, 4)));
    end
    ifStartAt = cyc + 1 + ifQ[0].delay;
    dmStartAt = cyc + 1 + dmQ[0].delay;
    runUntilIdle(20000, "t7");
    checkVal("t7_if_served", ifGntCount - gi, 120);
    checkVal("t7_dm_served", dmGntCount - gd, 120);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
